// File: rtl/cv32e40p_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_pkg
// Shared types and constants for the coprocessor (X-interface) result path.
//   x_result_entry_t        : one buffered writeback {rd, data}
//   X_RESULT_DEPTH_DEFAULT  : default number of buffered results
//   X_STARVE_LIMIT_DEFAULT  : default blocked-cycle count before a stall request
//   rd_onehot()             : destination register index to a 32-bit one-hot mask
// -----------------------------------------------------------------------------
package cv32e40p_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } x_result_entry_t;

  localparam int X_RESULT_DEPTH_DEFAULT = 4;
  localparam int X_STARVE_LIMIT_DEFAULT = 8;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    rd_onehot = 32'd1 << rd;
  endfunction

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_fifo
// Generic synchronous FIFO of x_result_entry_t, synchronous active-high reset.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_wdata : write request and entry (ignored while full)
//   i_pop           : read request (ignored while empty)
//   o_rdata         : head entry
//   o_full, o_empty : occupancy flags
//   o_count         : occupancy, 0..DEPTH
//   o_valid         : per-slot valid bit
//   o_rd            : per-slot destination register (qualify with o_valid)
// -----------------------------------------------------------------------------
module cv32e40p_x_result_fifo
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH = X_RESULT_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  x_result_entry_t          i_wdata,
  input  logic                     i_pop,
  output x_result_entry_t          o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [DEPTH-1:0]         o_valid,
  output logic [4:0]               o_rd [DEPTH]
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

  x_result_entry_t r_mem [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [DEPTH-1:0] r_valid;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == LP_DEPTH);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage is not reset; r_valid alone says which slots hold live data.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_do_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + AW'(1);
      end
      if (w_do_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_rdata = r_mem[r_head];
  assign o_count = r_count;
  assign o_valid = r_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) o_rd[i] = r_mem[i].rd;
  end

endmodule

// File: rtl/cv32e40p_x_result_buffer.sv
// -----------------------------------------------------------------------------
// cv32e40p_x_result_buffer
// Buffers X-interface result writebacks and releases them, in order, onto the
// execute stage's ALU write port whenever the core leaves that port free.
// Results with we=0 or rd=0 are accepted and dropped. A registered stall
// request is raised when the head result has been blocked for STARVE_LIMIT
// consecutive cycles.
// Optional build macro: X_RESULT_BYPASS_EN -- when the buffer is empty and the
// port is free, a storable incoming result is presented in the same cycle
// without being stored.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   x_result_valid_i/ready_o  : result handshake (transfer on valid & ready)
//   x_result_rd_i/we_i/data_i : result payload
//   wb_port_free_i            : ALU write port unused by the core this cycle
//   x_rvalid_o/x_rd_o/x_data_o: result presented on the write port (0 if idle)
//   pending_rd_o              : one-hot OR of buffered destinations
//   stall_req_o               : request ID stage stall
//   count_o                   : occupancy
// -----------------------------------------------------------------------------
module cv32e40p_x_result_buffer
  import cv32e40p_pkg::*;
#(
  parameter int DEPTH        = X_RESULT_DEPTH_DEFAULT,
  parameter int STARVE_LIMIT = X_STARVE_LIMIT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_result_valid_i,
  output logic                   x_result_ready_o,
  input  logic [4:0]             x_result_rd_i,
  input  logic                   x_result_we_i,
  input  logic [31:0]            x_result_data_i,
  input  logic                   wb_port_free_i,
  output logic                   x_rvalid_o,
  output logic [4:0]             x_rd_o,
  output logic [31:0]            x_data_o,
  output logic [31:0]            pending_rd_o,
  output logic                   stall_req_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam logic [7:0] LP_STARVE_LIMIT = 8'(STARVE_LIMIT);

  x_result_entry_t  w_wdata;
  x_result_entry_t  w_head;
  logic             w_full;
  logic             w_empty;
  logic [DEPTH-1:0] w_valid;
  logic [4:0]       w_rd [DEPTH];

  logic w_push_hs;
  logic w_storable;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  logic [7:0] r_starve;
  logic [7:0] w_starve_nxt;
  logic       r_stall;

  // Ready comes from the registered occupancy only (!full == count < DEPTH),
  // so a pop in the same cycle never makes room for a push.
  assign x_result_ready_o = ~w_full;
  assign w_push_hs        = x_result_valid_i & x_result_ready_o;
  assign w_storable       = x_result_we_i & (x_result_rd_i != 5'd0);
  assign w_pop            = ~rst & ~w_empty & wb_port_free_i;

`ifdef X_RESULT_BYPASS_EN
  assign w_bypass = ~rst & w_push_hs & w_storable & w_empty & wb_port_free_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push  = w_push_hs & w_storable & ~w_bypass;
  assign w_wdata = '{rd: x_result_rd_i, data: x_result_data_i};

  cv32e40p_x_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count_o),
    .o_valid (w_valid),
    .o_rd    (w_rd)
  );

  // Write-port drive: bypass and pop are mutually exclusive (bypass needs empty).
  always_comb begin
    x_rvalid_o = 1'b0;
    x_rd_o     = 5'd0;
    x_data_o   = 32'd0;
    if (w_bypass) begin
      x_rvalid_o = 1'b1;
      x_rd_o     = x_result_rd_i;
      x_data_o   = x_result_data_i;
    end else if (w_pop) begin
      x_rvalid_o = 1'b1;
      x_rd_o     = w_head.rd;
      x_data_o   = w_head.data;
    end
  end

  // Each live slot contributes its own bit, so duplicate rds stay flagged
  // until the last matching entry has left.
  always_comb begin
    pending_rd_o = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) pending_rd_o = pending_rd_o | rd_onehot(w_rd[i]);
    end
    pending_rd_o[0] = 1'b0;
  end

  // Starve counter: counts blocked cycles of a non-empty buffer, saturating.
  always_comb begin
    w_starve_nxt = r_starve;
    if (w_pop || w_empty) begin
      w_starve_nxt = 8'd0;
    end else if (!wb_port_free_i && (r_starve != 8'hFF)) begin
      w_starve_nxt = r_starve + 8'd1;
    end
  end

  // The stall flag is registered from the counter's next value: it rises the
  // cycle after the counter reaches the limit and drops the cycle after a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= 8'd0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt >= LP_STARVE_LIMIT);
    end
  end

  assign stall_req_o = r_stall;

endmodule

// File: tb/tb_cv32e40p_x_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_cv32e40p_x_result_buffer
// Directed bench for cv32e40p_x_result_buffer (DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Expectations for the X_RESULT_BYPASS_EN build are selected
// with the same macro.
// -----------------------------------------------------------------------------
module tb_cv32e40p_x_result_buffer;

  logic        clk;
  logic        rst;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [4:0]  x_result_rd_i;
  logic        x_result_we_i;
  logic [31:0] x_result_data_i;
  logic        wb_port_free_i;
  logic        x_rvalid_o;
  logic [4:0]  x_rd_o;
  logic [31:0] x_data_o;
  logic [31:0] pending_rd_o;
  logic        stall_req_o;
  logic [2:0]  count_o;

  int n_checks;
  int n_errors;

  cv32e40p_x_result_buffer #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .x_result_valid_i (x_result_valid_i),
    .x_result_ready_o (x_result_ready_o),
    .x_result_rd_i    (x_result_rd_i),
    .x_result_we_i    (x_result_we_i),
    .x_result_data_i  (x_result_data_i),
    .wb_port_free_i   (wb_port_free_i),
    .x_rvalid_o       (x_rvalid_o),
    .x_rd_o           (x_rd_o),
    .x_data_o         (x_data_o),
    .pending_rd_o     (pending_rd_o),
    .stall_req_o      (stall_req_o),
    .count_o          (count_o)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [31:0] data, input logic free);
    x_result_valid_i = v;
    x_result_rd_i    = rd;
    x_result_we_i    = we;
    x_result_data_i  = data;
    wb_port_free_i   = free;
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    sample();
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    n_checks++; if (x_result_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %0b exp 1", x_result_ready_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (pending_rd_o !== 32'd0) begin n_errors++; $display("FAIL reset_pending got %h exp 0", pending_rd_o); end
    n_checks++; if (stall_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %0b exp 0", stall_req_o); end
    next_cycle();
  endtask

  task automatic test_single();
    logic exp_v0;
    logic exp_v1;
    logic [2:0] exp_c1;
    logic [31:0] exp_p1;
`ifdef X_RESULT_BYPASS_EN
    exp_v0 = 1'b1; exp_v1 = 1'b0; exp_c1 = 3'd0; exp_p1 = 32'd0;
`else
    exp_v0 = 1'b0; exp_v1 = 1'b1; exp_c1 = 3'd1; exp_p1 = 32'h0000_0020;
`endif
    drive(1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b1);
    sample();
    n_checks++; if (x_rvalid_o !== exp_v0) begin n_errors++; $display("FAIL single_push_rvalid got %0b exp %0b", x_rvalid_o, exp_v0); end
    if (exp_v0) begin
      n_checks++; if (x_data_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_bypass_data got %h exp deadbeef", x_data_o); end
    end
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    sample();
    n_checks++; if (x_rvalid_o !== exp_v1) begin n_errors++; $display("FAIL single_pop_rvalid got %0b exp %0b", x_rvalid_o, exp_v1); end
    n_checks++; if (count_o !== exp_c1) begin n_errors++; $display("FAIL single_count got %0d exp %0d", count_o, exp_c1); end
    n_checks++; if (pending_rd_o !== exp_p1) begin n_errors++; $display("FAIL single_pending got %h exp %h", pending_rd_o, exp_p1); end
    if (exp_v1) begin
      n_checks++; if (x_rd_o !== 5'd5) begin n_errors++; $display("FAIL single_rd got %0d exp 5", x_rd_o); end
      n_checks++; if (x_data_o !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_data got %h exp deadbeef", x_data_o); end
    end
    next_cycle();
    sample();
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL single_idle_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (x_rd_o !== 5'd0 || x_data_o !== 32'd0) begin n_errors++; $display("FAIL single_idle_zero got rd %0d data %h exp 0 0", x_rd_o, x_data_o); end
    n_checks++; if (pending_rd_o !== 32'd0) begin n_errors++; $display("FAIL single_idle_pending got %h exp 0", pending_rd_o); end
    next_cycle();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 1'b1, 32'h100 + 32'(i), 1'b0);
      sample();
      n_checks++; if (x_result_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_ready_%0d got %0b exp 1", i, x_result_ready_o); end
      next_cycle();
    end
    // Full: an offered result must not be taken, even when a pop happens.
    drive(1'b1, 5'd10, 1'b1, 32'h10A, 1'b0);
    sample();
    n_checks++; if (x_result_ready_o !== 1'b0) begin n_errors++; $display("FAIL fill_full_ready got %0b exp 0", x_result_ready_o); end
    n_checks++; if (count_o !== 3'd4) begin n_errors++; $display("FAIL fill_count got %0d exp 4", count_o); end
    n_checks++; if (pending_rd_o !== 32'h0000_001E) begin n_errors++; $display("FAIL fill_pending got %h exp 0000001e", pending_rd_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL fill_blocked_rvalid got %0b exp 0", x_rvalid_o); end
    next_cycle();
    drive(1'b1, 5'd10, 1'b1, 32'h10A, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      sample();
      n_checks++; if (x_rvalid_o !== 1'b1) begin n_errors++; $display("FAIL drain_rvalid_%0d got %0b exp 1", k, x_rvalid_o); end
      n_checks++; if (x_rd_o !== 5'(k)) begin n_errors++; $display("FAIL drain_rd_%0d got %0d exp %0d", k, x_rd_o, k); end
      n_checks++; if (x_data_o !== 32'h100 + 32'(k)) begin n_errors++; $display("FAIL drain_data_%0d got %h exp %h", k, x_data_o, 32'h100 + 32'(k)); end
      n_checks++; if (x_result_ready_o !== (k != 1)) begin n_errors++; $display("FAIL drain_ready_%0d got %0b exp %0b", k, x_result_ready_o, (k != 1)); end
      next_cycle();
      drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    end
    sample();
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL drain_end_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL drain_end_count got %0d exp 0", count_o); end
    next_cycle();
  endtask

  task automatic test_discard();
    drive(1'b1, 5'd0, 1'b1, 32'h1234, 1'b1);
    sample();
    n_checks++; if (x_result_ready_o !== 1'b1) begin n_errors++; $display("FAIL discard_rd0_ready got %0b exp 1", x_result_ready_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL discard_rd0_rvalid got %0b exp 0", x_rvalid_o); end
    next_cycle();
    drive(1'b1, 5'd7, 1'b0, 32'h5678, 1'b1);
    sample();
    n_checks++; if (x_result_ready_o !== 1'b1) begin n_errors++; $display("FAIL discard_we0_ready got %0b exp 1", x_result_ready_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL discard_we0_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL discard_count_a got %0d exp 0", count_o); end
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    sample();
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL discard_count_b got %0d exp 0", count_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL discard_after_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (pending_rd_o !== 32'd0) begin n_errors++; $display("FAIL discard_pending got %h exp 0", pending_rd_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_rd [5];
    logic [2:0] exp_cnt [5];
`ifdef X_RESULT_BYPASS_EN
    exp_rd  = '{5'd20, 5'd21, 5'd22, 5'd0, 5'd0};
    exp_cnt = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
    exp_rd  = '{5'd0, 5'd20, 5'd21, 5'd22, 5'd0};
    exp_cnt = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0};
`endif
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 5'd20 + 5'(c), 1'b1, 32'h2000 + 32'(c), 1'b1);
      else       drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
      sample();
      n_checks++; if (x_rvalid_o !== (exp_rd[c] != 5'd0)) begin n_errors++; $display("FAIL b2b_rvalid_%0d got %0b exp %0b", c, x_rvalid_o, (exp_rd[c] != 5'd0)); end
      n_checks++; if (x_rd_o !== exp_rd[c]) begin n_errors++; $display("FAIL b2b_rd_%0d got %0d exp %0d", c, x_rd_o, exp_rd[c]); end
      n_checks++; if (count_o !== exp_cnt[c]) begin n_errors++; $display("FAIL b2b_count_%0d got %0d exp %0d", c, count_o, exp_cnt[c]); end
      next_cycle();
    end
  endtask

  task automatic test_starve();
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) drive(1'b1, 5'd3, 1'b1, 32'h33, 1'b0);
      else        drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
      sample();
      n_checks++; if (stall_req_o !== (c >= 9)) begin n_errors++; $display("FAIL starve_stall_c%0d got %0b exp %0b", c, stall_req_o, (c >= 9)); end
      next_cycle();
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    sample();
    n_checks++; if (x_rvalid_o !== 1'b1 || x_rd_o !== 5'd3) begin n_errors++; $display("FAIL starve_pop got rvalid %0b rd %0d exp 1 3", x_rvalid_o, x_rd_o); end
    n_checks++; if (stall_req_o !== 1'b1) begin n_errors++; $display("FAIL starve_stall_pop got %0b exp 1", stall_req_o); end
    next_cycle();
    sample();
    n_checks++; if (stall_req_o !== 1'b0) begin n_errors++; $display("FAIL starve_stall_after got %0b exp 0", stall_req_o); end
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL starve_count got %0d exp 0", count_o); end
    next_cycle();
  endtask

  task automatic test_dup_and_reset();
    drive(1'b1, 5'd9, 1'b1, 32'hA, 1'b0);
    next_cycle();
    drive(1'b1, 5'd9, 1'b1, 32'hB, 1'b0);
    next_cycle();
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b1);
    sample();
    n_checks++; if (x_rvalid_o !== 1'b1 || x_data_o !== 32'hA) begin n_errors++; $display("FAIL dup_pop1 got rvalid %0b data %h exp 1 a", x_rvalid_o, x_data_o); end
    n_checks++; if (pending_rd_o !== 32'h200) begin n_errors++; $display("FAIL dup_pending_2 got %h exp 00000200", pending_rd_o); end
    next_cycle();
    wb_port_free_i = 1'b0;
    sample();
    n_checks++; if (pending_rd_o !== 32'h200) begin n_errors++; $display("FAIL dup_pending_1 got %h exp 00000200", pending_rd_o); end
    n_checks++; if (count_o !== 3'd1) begin n_errors++; $display("FAIL dup_count_1 got %0d exp 1", count_o); end
    next_cycle();
    wb_port_free_i = 1'b1;
    sample();
    n_checks++; if (x_rvalid_o !== 1'b1 || x_data_o !== 32'hB) begin n_errors++; $display("FAIL dup_pop2 got rvalid %0b data %h exp 1 b", x_rvalid_o, x_data_o); end
    next_cycle();
    wb_port_free_i = 1'b0;
    sample();
    n_checks++; if (pending_rd_o !== 32'd0) begin n_errors++; $display("FAIL dup_pending_0 got %h exp 0", pending_rd_o); end
    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd11 + 5'(i), 1'b1, 32'h300 + 32'(i), 1'b0);
      next_cycle();
    end
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    sample();
    n_checks++; if (count_o !== 3'd3) begin n_errors++; $display("FAIL rst_pre_count got %0d exp 3", count_o); end
    n_checks++; if (pending_rd_o !== 32'h0000_3800) begin n_errors++; $display("FAIL rst_pre_pending got %h exp 00003800", pending_rd_o); end
    next_cycle();
    rst = 1'b1;
    wb_port_free_i = 1'b1;
    sample();
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL rst_cycle_rvalid got %0b exp 0", x_rvalid_o); end
    next_cycle();
    rst = 1'b0;
    sample();
    n_checks++; if (count_o !== 3'd0) begin n_errors++; $display("FAIL rst_post_count got %0d exp 0", count_o); end
    n_checks++; if (pending_rd_o !== 32'd0) begin n_errors++; $display("FAIL rst_post_pending got %h exp 0", pending_rd_o); end
    n_checks++; if (x_rvalid_o !== 1'b0) begin n_errors++; $display("FAIL rst_post_rvalid got %0b exp 0", x_rvalid_o); end
    n_checks++; if (x_result_ready_o !== 1'b1) begin n_errors++; $display("FAIL rst_post_ready got %0b exp 1", x_result_ready_o); end
    next_cycle();
  endtask

  // Sequence and final report
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'd0, 1'b0);
    test_reset();
    test_single();
    test_fill_drain();
    test_discard();
    test_back_to_back();
    test_starve();
    test_dup_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
